// File: rtl/mem_responder.sv
// Single-outstanding memory responder: accepts one block read/write, waits
// LATENCY cycles, then holds a response until the cache takes it.
module mem_responder #(
    parameter int unsigned LATENCY    = 4,
    parameter int unsigned BLOCK_BITS = 6
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [7:0]  req_op,
    input  logic [47:0] req_addr,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [7:0]  rsp_op,
    output logic [47:0] rsp_addr,
    output logic [31:0] rsp_data,
    output logic        rsp_err,
    output logic [11:0] num_mem_reads,
    output logic [11:0] num_mem_writes
);

    localparam int unsigned OP_W   = 8;
    localparam int unsigned ADDR_W = 48;
    localparam int unsigned DATA_W = 32;
    localparam int unsigned CNT_W  = 4;
    localparam int unsigned CTR_W  = 12;

    localparam logic [OP_W-1:0]   OP_READ  = 8'h52;
    localparam logic [OP_W-1:0]   OP_WRITE = 8'h57;
    localparam logic [CTR_W-1:0]  CTR_MAX  = 12'hFFF;
    localparam logic [CNT_W-1:0]  CNT_LOAD = CNT_W'(LATENCY - 1);
    localparam logic [ADDR_W-1:0] BLK_MASK = ADDR_W'((64'd1 << BLOCK_BITS) - 64'd1);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_BUSY = 2'd1;
    localparam logic [1:0] ST_RESP = 2'd2;

    logic [1:0]        r_state;
    logic [CNT_W-1:0]  r_cnt;
    logic [OP_W-1:0]   r_op;
    logic [ADDR_W-1:0] r_addr;
    logic [CTR_W-1:0]  r_num_reads;
    logic [CTR_W-1:0]  r_num_writes;

    logic              r_req_ready;
    logic              r_rsp_valid;
    logic [OP_W-1:0]   r_rsp_op;
    logic [ADDR_W-1:0] r_rsp_addr;
    logic [DATA_W-1:0] r_rsp_data;
    logic              r_rsp_err;

    logic [1:0]        w_next_state;
    logic              w_accept;
    logic              w_cap_read;
    logic              w_cap_write;
    logic [ADDR_W-1:0] w_blk_addr;
    logic [DATA_W-1:0] w_fill_data;

    // Next-state decode; accept only in IDLE so at most one transaction is live.
    always_comb begin
        w_next_state = r_state;
        w_accept     = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (req_valid) begin
                    w_accept     = 1'b1;
                    w_next_state = ST_BUSY;
                end
            end
            ST_BUSY: begin
                if (r_cnt == '0) begin
                    w_next_state = ST_RESP;
                end
            end
            ST_RESP: begin
                if (rsp_ready) begin
                    w_next_state = ST_IDLE;
                end
            end
            default: w_next_state = ST_IDLE;
        endcase
    end

    // Response payload derived from the captured request.
    always_comb begin
        w_cap_read  = (r_op == OP_READ);
        w_cap_write = (r_op == OP_WRITE);
        w_blk_addr  = r_addr & ~BLK_MASK;
        w_fill_data = w_cap_read ? w_blk_addr[DATA_W-1:0] : '0;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state      <= ST_IDLE;
            r_cnt        <= '0;
            r_op         <= '0;
            r_addr       <= '0;
            r_num_reads  <= '0;
            r_num_writes <= '0;
            r_req_ready  <= 1'b1;
            r_rsp_valid  <= 1'b0;
            r_rsp_op     <= '0;
            r_rsp_addr   <= '0;
            r_rsp_data   <= '0;
            r_rsp_err    <= 1'b0;
        end else begin
            r_state <= w_next_state;

            if (w_accept) begin
                r_op   <= req_op;
                r_addr <= req_addr;
                r_cnt  <= CNT_LOAD;
                if (req_op == OP_READ && r_num_reads != CTR_MAX) begin
                    r_num_reads <= r_num_reads + CTR_W'(1);
                end
                if (req_op == OP_WRITE && r_num_writes != CTR_MAX) begin
                    r_num_writes <= r_num_writes + CTR_W'(1);
                end
            end else if (r_state == ST_BUSY && r_cnt != '0) begin
                r_cnt <= r_cnt - CNT_W'(1);
            end

            // Outputs track the next state so they are valid with it; zero outside RESP.
            r_req_ready <= (w_next_state == ST_IDLE);
            r_rsp_valid <= (w_next_state == ST_RESP);
            if (w_next_state == ST_RESP) begin
                r_rsp_op   <= r_op;
                r_rsp_addr <= w_blk_addr;
                r_rsp_data <= w_fill_data;
                r_rsp_err  <= ~(w_cap_read | w_cap_write);
            end else begin
                r_rsp_op   <= '0;
                r_rsp_addr <= '0;
                r_rsp_data <= '0;
                r_rsp_err  <= 1'b0;
            end
        end
    end

    assign req_ready      = r_req_ready;
    assign rsp_valid      = r_rsp_valid;
    assign rsp_op         = r_rsp_op;
    assign rsp_addr       = r_rsp_addr;
    assign rsp_data       = r_rsp_data;
    assign rsp_err        = r_rsp_err;
    assign num_mem_reads  = r_num_reads;
    assign num_mem_writes = r_num_writes;

endmodule

// File: doc/mem_responder.md
MEM_RESPONDER -- requirements
Module: mem_responder

Interface
REQ-001 The module SHALL have parameter LATENCY, default 4, meaning cycles from request acceptance to response valid (legal range 1..15).
REQ-002 The module SHALL have parameter BLOCK_BITS, default 6, meaning log2 of block size in bytes.
REQ-003 The module SHALL have port clk, input, 1, the single clock; all state updates on rising edge.
REQ-004 The module SHALL have port reset, input, 1, with synchronous, active-high reset.
REQ-005 The module SHALL have port req_valid, input, 1, meaning the cache presents a memory request.
REQ-006 The module SHALL have port req_ready, output, 1, meaning the responder can accept a request this cycle.
REQ-007 The module SHALL have port req_op, input, 8, the ASCII op code: 8'h52 = R (block fill), 8'h57 = W (write-back).
REQ-008 The module SHALL have port req_addr, input, 48, the byte address of the request.
REQ-009 The module SHALL have port rsp_valid, output, 1, meaning a response is presented.
REQ-010 The module SHALL have port rsp_ready, input, 1, meaning the cache accepts the response.
REQ-011 The module SHALL have port rsp_op, output, 8, echoing the captured req_op.
REQ-012 The module SHALL have port rsp_addr, output, 48, the captured address with bits [BLOCK_BITS-1:0] zeroed.
REQ-013 The module SHALL have port rsp_data, output, 32, the fill data: rsp_addr[31:0] for R, 0 for W or error.
REQ-014 The module SHALL have port rsp_err, output, 1, which is high when the captured op is neither 8'h52 nor 8'h57.
REQ-015 The module SHALL have ports num_mem_reads and num_mem_writes, output, 12 each, the accepted R and W counts.

Function
REQ-016 The FSM SHALL have states IDLE, BUSY and RESP; req_ready = (state==IDLE); rsp_valid = (state==RESP).
REQ-017 The module SHALL accept a request on an edge where state==IDLE and req_valid=1, then capture req_op/req_addr, load cnt=LATENCY-1 and go to BUSY.
REQ-018 In BUSY, the module SHALL go to RESP when cnt==0, else decrement cnt; rsp_valid therefore rises exactly LATENCY edges after the accept edge.
REQ-019 In RESP, on an edge with rsp_ready=1, the module SHALL go to IDLE; otherwise it holds RESP with all rsp_* outputs stable.
REQ-020 At most one transaction SHALL be outstanding; req_ready is 0 from the accept edge until the edge after the response handshake, so no same-cycle response+accept occurs.
REQ-021 The module SHALL ignore req_valid/req_op/req_addr outside IDLE; changes to them SHALL NOT affect captured values.
REQ-022 On accept, the module SHALL increment num_mem_reads for op 8'h52 and num_mem_writes for op 8'h57; both counters saturate at 12'hFFF.
REQ-023 An invalid op SHALL be accepted and timed normally and responded with rsp_err=1 and rsp_data=0, with no counter incremented.
REQ-024 rsp_op, rsp_addr, rsp_data and rsp_err SHALL be 0 whenever rsp_valid=0.
REQ-025 rsp_valid held with rsp_ready=0 for any number of cycles SHALL NOT lose or alter the response.

Reset
REQ-026 While reset=1 at an edge, the module SHALL set state=IDLE, cnt=0, captured op/addr=0, and both counters=0; reset has priority over every other event.
REQ-027 After reset, outputs SHALL be req_ready=1, rsp_valid=0, rsp_op=0, rsp_addr=0, rsp_data=0, rsp_err=0, num_mem_reads=0 and num_mem_writes=0.
REQ-028 Reset asserted in BUSY or RESP SHALL abort the transaction; no response for it is ever produced.

Verification
REQ-029 LATENCY=4, R at 48'h7fff493822b8 accepted at edge N, rsp_ready=1 -> rsp_valid high after edge N+4 for one cycle, rsp_addr=48'h7fff49382280, rsp_data=32'h49382280, num_mem_reads=1, req_ready high after edge N+5.
REQ-030 W at 48'h0000006324d8 with rsp_ready=0 for 10 cycles after valid -> rsp_valid stays high, outputs stable, rsp_data=0, rsp_op=8'h57; handshake on release -> num_mem_writes=1.
REQ-031 req_op=8'h41 -> response after LATENCY with rsp_err=1, rsp_data=0, and both counters unchanged.
REQ-032 req_valid held high continuously across 3 requests, rsp_ready=1 -> exactly one accept per LATENCY+2 cycles, with no overlap.
REQ-033 Reset asserted 2 cycles after an accept -> no rsp_valid ever appears for that request; counters=0 and req_ready=1 after the reset edge.
REQ-034 4100 R requests -> num_mem_reads saturates at 12'hFFF and num_mem_writes=0.
